dmem_port_arbiter: RTL and testbench

//   Two-requester arbiter/sequencer in front of the byte-addressed data RAM (clka, wea[3:0], addra, dina, douta).

---
 rtl/dmem_port_arbiter_pkg.sv | 54 +++++
 rtl/dmem_port_arbiter_if.sv | 39 +++
 rtl/dmem_load_ext.sv | 31 +++
 rtl/dmem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dmem_pkg
// Description : Shared codes and helpers for the data-memory port arbiter:
//               access size codes, arbiter state encoding, RAM byte-enable
//               patterns, byte-enable and access-legality helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;

  localparam logic [3:0] WEA_B = 4'b0001;
  localparam logic [3:0] WEA_H = 4'b0011;
  localparam logic [3:0] WEA_W = 4'b1111;

  // Store data is right-aligned, so enables always start at lane 0.
  function automatic logic [3:0] size_to_wea(input logic [1:0] size);
    logic [3:0] wea;
    case (size)
      SZ_B:    wea = WEA_B;
      SZ_H:    wea = WEA_H;
      SZ_W:    wea = WEA_W;
      default: wea = 4'b0000;
    endcase
    return wea;
  endfunction

  // Misaligned, illegal size, upper half of the address space or past the
  // end of the RAM.
  function automatic logic access_err(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input logic [31:0] ram_bytes);
    logic bad_align;
    case (size)
      SZ_B:    bad_align = 1'b0;
      SZ_H:    bad_align = addr[0];
      SZ_W:    bad_align = |addr[1:0];
      default: bad_align = 1'b1;
    endcase
    return bad_align | addr[31] | (addr >= ram_bytes);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : dmem_req_if
// Description : One requester port of the data-memory arbiter.
//   req     requester -> arbiter  access request, held until gnt
//   we      requester -> arbiter  1 = store, 0 = load
//   size    requester -> arbiter  0 byte, 1 half, 2 word, 3 illegal
//   zext    requester -> arbiter  loads: 1 = zero-extend, 0 = sign-extend
//   addr    requester -> arbiter  byte address
//   wdata   requester -> arbiter  right-aligned store data
//   gnt     arbiter -> requester  one-cycle pulse, request accepted
//   rvalid  arbiter -> requester  one-cycle pulse, access complete
//   rdata   arbiter -> requester  extended load data (0 for stores/errors)
//   err     arbiter -> requester  access error, valid with rvalid
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_req_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        zext;  // "unsigned" is a reserved word
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, size, zext, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, size, zext, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : dmem_load_ext
// Description : Combinational load-data extender. Picks the low byte, low
//               half or full word of the RAM read data and sign- or
//               zero-extends it. Shared with the CPU bypass path.
//   i_dout   in  32  RAM read data (addressed byte in lane 0)
//   i_size   in  2   access size code
//   i_zext   in  1   1 = zero-extend, 0 = sign-extend
//   o_rdata  out 32  extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] i_dout,
  input  logic [1:0]  i_size,
  input  logic        i_zext,
  output logic [31:0] o_rdata
);

  always_comb begin
    case (i_size)
      SZ_B:    o_rdata = {{24{~i_zext & i_dout[7]}},  i_dout[7:0]};
      SZ_H:    o_rdata = {{16{~i_zext & i_dout[15]}}, i_dout[15:0]};
      default: o_rdata = i_dout;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Two-requester arbiter/sequencer in front of the single-port
//               byte-addressed data RAM. m0 = CPU MEM stage, m1 = loader /
//               debug port. Each access takes IDLE -> ACC -> RESP.
//   clk       in   1   clock (also the RAM clock)
//   rstn      in   1   asynchronous active-low reset
//   m0, m1    slave    requester ports (dmem_req_if)
//   ram_wea   out  4   RAM byte write enables
//   ram_addr  out  32  RAM byte address (0 outside ACC)
//   ram_din   out  32  RAM write data (0 outside ACC)
//   ram_dout  in   32  RAM read data, sampled at the edge ending ACC
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_BYTES = 1024,
  parameter bit          RR_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  dmem_req_if.slave   m0,
  dmem_req_if.slave   m1,
  output logic [3:0]  ram_wea,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  localparam logic [31:0] c_ram_limit = 32'(RAM_BYTES);

  state_t           r_state;
  logic             r_last;   // id granted most recently
  logic             r_id;
  logic             r_we;
  logic [1:0]       r_size;
  logic             r_zext;
  logic             r_lerr;
  logic [1:0]       r_gnt;
  logic [1:0]       r_rvalid;
  logic [1:0]       r_err;
  logic [1:0][31:0] r_rdata;

  logic        w_any;
  logic        w_sel;
  logic        w_we;
  logic [1:0]  w_size;
  logic        w_zext;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_err;
  logic [31:0] w_ext;

  // Winner selection and mux of its request fields.
  always_comb begin
    w_any = m0.req | m1.req;
    if (m0.req && m1.req) begin
      w_sel = RR_EN ? ~r_last : 1'b0;
    end else begin
      w_sel = m1.req;  // only m1 requesting, or nobody (then unused)
    end
    if (w_sel) begin
      w_we    = m1.we;
      w_size  = m1.size;
      w_zext  = m1.zext;
      w_addr  = m1.addr;
      w_wdata = m1.wdata;
    end else begin
      w_we    = m0.we;
      w_size  = m0.size;
      w_zext  = m0.zext;
      w_addr  = m0.addr;
      w_wdata = m0.wdata;
    end
    w_err = access_err(w_size, w_addr, c_ram_limit);
  end

  dmem_load_ext u_load_ext (
    .i_dout  (ram_dout),
    .i_size  (r_size),
    .i_zext  (r_zext),
    .o_rdata (w_ext)
  );

  // All port and RAM outputs are pulses/values owned by one state and
  // default back to zero every cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_last   <= 1'b1;     // m0 wins the first tie
      r_id     <= 1'b0;
      r_we     <= 1'b0;
      r_size   <= SZ_B;
      r_zext   <= 1'b0;
      r_lerr   <= 1'b0;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_err    <= '0;
      r_rdata  <= '0;
      ram_wea  <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_err    <= '0;
      r_rdata  <= '0;
      ram_wea  <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_id         <= w_sel;
            r_last       <= w_sel;
            r_we         <= w_we;
            r_size       <= w_size;
            r_zext       <= w_zext;
            r_lerr       <= w_err;
            r_gnt[w_sel] <= 1'b1;
            // An erroneous access never reaches the RAM.
            if (!w_err) begin
              ram_addr <= w_addr;
              ram_din  <= w_wdata;
              if (w_we) begin
                ram_wea <= size_to_wea(w_size);
              end
            end
            r_state <= ST_ACC;
          end
        end
        ST_ACC: begin
          r_rvalid[r_id] <= 1'b1;
          r_err[r_id]    <= r_lerr;
          r_rdata[r_id]  <= (r_lerr || r_we) ? 32'h0 : w_ext;
          r_state        <= ST_RESP;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0.gnt    = r_gnt[0];
  assign m0.rvalid = r_rvalid[0];
  assign m0.err    = r_err[0];
  assign m0.rdata  = r_rdata[0];
  assign m1.gnt    = r_gnt[1];
  assign m1.rvalid = r_rvalid[1];
  assign m1.err    = r_err[1];
  assign m1.rdata  = r_rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Directed self-checking bench for dmem_port_arbiter. Holds a
//               byte-wide RAM model, a round-robin DUT and a fixed-priority
//               DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;
  import dmem_pkg::*;

  logic        clk;
  logic        rstn;
  logic [3:0]  ram_wea;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [3:0]  fp_wea;
  logic [31:0] fp_addr;
  logic [31:0] fp_din;

  int nchk;
  int nfail;
  int n;
  logic g0;
  logic g1;

  dmem_req_if u_m0 ();
  dmem_req_if u_m1 ();
  dmem_req_if u_f0 ();
  dmem_req_if u_f1 ();

  dmem_port_arbiter #(.RAM_BYTES(1024), .RR_EN(1'b1)) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .m0       (u_m0.slave),
    .m1       (u_m1.slave),
    .ram_wea  (ram_wea),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  dmem_port_arbiter #(.RAM_BYTES(1024), .RR_EN(1'b0)) u_dut_fp (
    .clk      (clk),
    .rstn     (rstn),
    .m0       (u_f0.slave),
    .m1       (u_f1.slave),
    .ram_wea  (fp_wea),
    .ram_addr (fp_addr),
    .ram_din  (fp_din),
    .ram_dout (32'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM model: lane i of din/dout is byte addr+i, asynchronous read.
  logic [7:0] mem [0:1023];
  logic [9:0] ra;
  assign ra       = ram_addr[9:0];
  assign ram_dout = {mem[ra + 10'd3], mem[ra + 10'd2], mem[ra + 10'd1], mem[ra]};

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
        if (ram_wea[i]) mem[ram_addr[9:0] + 10'(i)] = ram_din[8*i +: 8];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memw(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic req, input logic we, input logic [1:0] size,
                       input logic zext, input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      u_m0.we = we; u_m0.size = size; u_m0.zext = zext; u_m0.addr = addr; u_m0.wdata = wdata;
      u_m0.req = req;
    end else begin
      u_m1.we = we; u_m1.size = size; u_m1.zext = zext; u_m1.addr = addr; u_m1.wdata = wdata;
      u_m1.req = req;
    end
  endtask

  task automatic set_req(input int p, input logic v);
    if (p == 0) u_m0.req = v;
    else        u_m1.req = v;
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 0) ? u_m0.gnt : u_m1.gnt;
  endfunction
  function automatic logic rvalid_of(input int p);
    return (p == 0) ? u_m0.rvalid : u_m1.rvalid;
  endfunction
  function automatic logic [31:0] rdata_of(input int p);
    return (p == 0) ? u_m0.rdata : u_m1.rdata;
  endfunction
  function automatic logic err_of(input int p);
    return (p == 0) ? u_m0.err : u_m1.err;
  endfunction

  // One access on port p, started in an IDLE cycle.
  task automatic access(input string tag, input int p, input logic we, input logic [1:0] sz,
                        input logic zx, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input logic [3:0] exp_wea);
    int k;
    logic g;
    logic [3:0]  wea_s;
    logic [31:0] addr_s;
    @(negedge clk);
    drive(p, 1'b1, we, sz, zx, addr, wdata);
    k = 0;
    g = 1'b0;
    while (!g && k < 10) begin
      @(negedge clk);
      k++;
      g = gnt_of(p);
    end
    wea_s  = ram_wea;
    addr_s = ram_addr;
    set_req(p, 1'b0);
    check({tag, "_gnt"},  32'(g), 32'd1);
    check({tag, "_lat"},  k, 1);
    check({tag, "_wea"},  32'(wea_s), 32'(exp_wea));
    check({tag, "_addr"}, addr_s, exp_err ? 32'h0 : addr);
    @(negedge clk);
    check({tag, "_rvalid"}, 32'(rvalid_of(p)), 32'd1);
    check({tag, "_err"},    32'(err_of(p)), 32'(exp_err));
    check({tag, "_rdata"},  rdata_of(p), exp_rdata);
    check({tag, "_addr_resp"}, ram_addr, 32'h0);
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    rstn  = 1'b0;
    drive(0, 1'b0, 1'b0, SZ_B, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, SZ_B, 1'b0, 32'h0, 32'h0);
    u_f0.req = 1'b0; u_f0.we = 1'b0; u_f0.size = SZ_W; u_f0.zext = 1'b0; u_f0.addr = 32'h0; u_f0.wdata = 32'h0;
    u_f1.req = 1'b0; u_f1.we = 1'b0; u_f1.size = SZ_W; u_f1.zext = 1'b0; u_f1.addr = 32'h0; u_f1.wdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_m0", 32'({u_m0.gnt, u_m0.rvalid, u_m0.err}), 32'h0);
    check("rst_m1", 32'({u_m1.gnt, u_m1.rvalid, u_m1.err}), 32'h0);
    check("rst_rdata", u_m0.rdata | u_m1.rdata, 32'h0);
    check("rst_wea", 32'(ram_wea), 32'h0);
    check("rst_ram_bus", ram_addr | ram_din, 32'h0);
    check("rst_state", 32'(u_dut.r_state), 32'(ST_IDLE));
    rstn = 1'b1;

    // Basic stores and loads
    access("sw10",  0, 1'b1, SZ_W, 1'b0, 32'h10, 32'h12345678, 32'h0, 1'b0, WEA_W);
    check("ram_10_13", memw(32'h10), 32'h12345678);
    check("ram_10", 32'(mem[16]), 32'h78);
    access("lw10",  0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0, 4'h0);
    access("sb21",  0, 1'b1, SZ_B, 1'b0, 32'h21, 32'h80, 32'h0, 1'b0, WEA_B);
    access("lb21",  0, 1'b0, SZ_B, 1'b0, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0, 4'h0);
    access("lbu21", 0, 1'b0, SZ_B, 1'b1, 32'h21, 32'h0, 32'h00000080, 1'b0, 4'h0);
    access("sh30",  0, 1'b1, SZ_H, 1'b0, 32'h30, 32'hFFFF8001, 32'h0, 1'b0, WEA_H);
    check("ram_30_33", memw(32'h30), 32'h00008001);
    access("lh30",  0, 1'b0, SZ_H, 1'b0, 32'h30, 32'h0, 32'hFFFF8001, 1'b0, 4'h0);
    access("lhu30", 0, 1'b0, SZ_H, 1'b1, 32'h30, 32'h0, 32'h00008001, 1'b0, 4'h0);
    access("sw3fc", 0, 1'b1, SZ_W, 1'b0, 32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0, WEA_W);
    access("lw3fc", 0, 1'b0, SZ_W, 1'b0, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0, 4'h0);

    // Error accesses
    access("e_lw12",  0, 1'b0, SZ_W, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 4'h0);
    access("e_lh13",  0, 1'b0, SZ_H, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 4'h0);
    access("e_hi",    0, 1'b0, SZ_W, 1'b0, 32'h80000000, 32'h0, 32'h0, 1'b1, 4'h0);
    access("e_400",   0, 1'b0, SZ_W, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 4'h0);
    access("e_sz3",   0, 1'b0, SZ_X, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 4'h0);
    access("e_sw12",  0, 1'b1, SZ_W, 1'b0, 32'h12, 32'hDEADBEEF, 32'h0, 1'b1, 4'h0);
    access("e_sb400", 0, 1'b1, SZ_B, 1'b0, 32'h400, 32'hFF, 32'h0, 1'b1, 4'h0);
    check("e_ram_10", memw(32'h10), 32'h12345678);
    check("e_ram_14", memw(32'h14), 32'h0);
    check("e_ram_0",  memw(32'h0), 32'h0);

    // Reset in the ACC cycle of a store
    @(negedge clk);
    drive(0, 1'b1, 1'b1, SZ_W, 1'b0, 32'h40, 32'hA5A5A5A5);
    @(negedge clk);
    check("rma_gnt", 32'(u_m0.gnt), 32'd1);
    check("rma_wea_acc", 32'(ram_wea), 32'(WEA_W));
    set_req(0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("rma_wea_async", 32'(ram_wea), 32'h0);
    check("rma_state", 32'(u_dut.r_state), 32'(ST_IDLE));
    repeat (2) begin
      @(negedge clk);
      check("rma_no_rvalid", 32'(u_m0.rvalid), 32'h0);
    end
    check("rma_ram", memw(32'h40), 32'h0);
    rstn = 1'b1;

    // Both ports requesting continuously, round robin from reset
    @(negedge clk);
    drive(0, 1'b1, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
    for (int k = 0; k < 4; k++) begin
      n  = 0;
      g0 = 1'b0;
      g1 = 1'b0;
      while (!(g0 | g1) && n < 10) begin
        @(negedge clk);
        n++;
        g0 = u_m0.gnt;
        g1 = u_m1.gnt;
      end
      check("arb_gnt_seen", 32'(g0 | g1), 32'd1);
      check("arb_onehot", 32'(g0 & g1), 32'd0);
      check("arb_order", 32'(g1), 32'(k % 2));
      check("arb_spacing", n, (k == 0) ? 1 : 2);
      @(negedge clk);
      if (g1) begin
        check("arb_m1_rvalid", 32'(u_m1.rvalid), 32'd1);
        check("arb_m1_rdata", u_m1.rdata, 32'h00008000);
        check("arb_m0_quiet", 32'({u_m0.rvalid, u_m0.err}) | u_m0.rdata, 32'h0);
      end else begin
        check("arb_m0_rvalid", 32'(u_m0.rvalid), 32'd1);
        check("arb_m0_rdata", u_m0.rdata, 32'h12345678);
        check("arb_m1_quiet", 32'({u_m1.rvalid, u_m1.err}) | u_m1.rdata, 32'h0);
      end
    end
    set_req(0, 1'b0);
    set_req(1, 1'b0);

    // Abandoned store left memory untouched; port works after reset
    access("post_lw40", 0, 1'b0, SZ_W, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 4'h0);
    access("post_sw40", 0, 1'b1, SZ_W, 1'b0, 32'h40, 32'h0BADF00D, 32'h0, 1'b0, WEA_W);
    access("post_lw40b", 0, 1'b0, SZ_W, 1'b0, 32'h40, 32'h0, 32'h0BADF00D, 1'b0, 4'h0);

    // m1 raised during the RESP of an m0 access
    @(negedge clk);
    drive(0, 1'b1, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("busy_m0_gnt", 32'(u_m0.gnt), 32'd1);
    set_req(0, 1'b0);
    @(negedge clk);
    check("busy_m0_rvalid", 32'(u_m0.rvalid), 32'd1);
    drive(1, 1'b1, 1'b0, SZ_B, 1'b1, 32'h21, 32'h0);
    @(negedge clk);
    check("busy_m1_nogAnt_idle", 32'(u_m1.gnt), 32'd0);
    @(negedge clk);
    check("busy_m1_gnt", 32'(u_m1.gnt), 32'd1);
    set_req(1, 1'b0);
    @(negedge clk);
    check("busy_m1_rvalid", 32'(u_m1.rvalid), 32'd1);
    check("busy_m1_rdata", u_m1.rdata, 32'h00000080);

    // Fixed priority: m0 keeps winning while it requests
    @(negedge clk);
    u_f0.addr = 32'h100; u_f0.wdata = 32'h55; u_f0.req = 1'b1;
    u_f1.addr = 32'h104; u_f1.req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n  = 0;
      g0 = 1'b0;
      g1 = 1'b0;
      while (!(g0 | g1) && n < 10) begin
        @(negedge clk);
        n++;
        g0 = u_f0.gnt;
        g1 = u_f1.gnt;
      end
      check("fp_gnt_seen", 32'(g0 | g1), 32'd1);
      check("fp_order", 32'({g1, g0}), (k == 3) ? 32'd2 : 32'd1);
      if (k == 0) begin
        check("fp_addr", fp_addr, 32'h100);
        check("fp_din", fp_din, 32'h55);
        check("fp_wea", 32'(fp_wea), 32'h0);
      end
      if (k == 2) u_f0.req = 1'b0;
      if (k == 3) u_f1.req = 1'b0;
      @(negedge clk);
      check("fp_rvalid", 32'({u_f1.rvalid, u_f0.rvalid}), (k == 3) ? 32'd2 : 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
`default_nettype wire
